// File: rtl/vga_timing_pkg.sv
// Shared raster timing types and 640x480@60 default constants for vga_timing_gen.
package vga_timing_pkg;

  typedef struct packed {
    int unsigned active;
    int unsigned fp;
    int unsigned sync;
    int unsigned bp;
  } vga_timing_t;

  localparam vga_timing_t VGA_640X480_H = '{active: 640, fp: 16, sync: 96, bp: 48};
  localparam vga_timing_t VGA_640X480_V = '{active: 480, fp: 10, sync: 2,  bp: 33};
  localparam int          VGA_640X480_CLK_DIV = 4;

  function automatic int unsigned total(input vga_timing_t t);
    return t.active + t.fp + t.sync + t.bp;
  endfunction

endpackage

// File: rtl/vga_pixel_tick.sv
// Pixel-clock enable: one-clk p_tick every CLK_DIV clks while en is high; div holds while en is low.
module vga_pixel_tick #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  output logic p_tick
);

  localparam int unsigned   DW       = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

  logic [DW-1:0] div;
  logic          div_last;

  assign div_last = (div == DIV_LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      div <= '0;
    end else if (en) begin
      div <= div_last ? '0 : div + 1'b1;
    end
  end

  // Qualified by reset so no tick leaks out while reset is held (CLK_DIV == 1 case).
  assign p_tick = en && reset && div_last;

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing generator: counters, sync/DE decode and line/frame strobes.
// Optional frame counter output enabled by defining VGA_TIMING_FRAME_CNT_EN.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int unsigned H_ACTIVE = VGA_640X480_H.active,
  parameter int unsigned H_FP     = VGA_640X480_H.fp,
  parameter int unsigned H_SYNC   = VGA_640X480_H.sync,
  parameter int unsigned H_BP     = VGA_640X480_H.bp,
  parameter int unsigned V_ACTIVE = VGA_640X480_V.active,
  parameter int unsigned V_FP     = VGA_640X480_V.fp,
  parameter int unsigned V_SYNC   = VGA_640X480_V.sync,
  parameter int unsigned V_BP     = VGA_640X480_V.bp,
  parameter logic        HS_POL   = 1'b0,
  parameter logic        VS_POL   = 1'b0,
  parameter int          CLK_DIV  = VGA_640X480_CLK_DIV,
  parameter int unsigned XW       = $clog2(H_ACTIVE + H_FP + H_SYNC + H_BP),
  parameter int unsigned YW       = $clog2(V_ACTIVE + V_FP + V_SYNC + V_BP)
`ifdef VGA_TIMING_FRAME_CNT_EN
  , parameter int unsigned FRAME_W = 8
`endif
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          en,
  output logic          p_tick,
  output logic          h_sync,
  output logic          v_sync,
  output logic          DE,
  output logic [XW-1:0] pixel_x,
  output logic [YW-1:0] pixel_y,
  output logic          line_end,
  output logic          frame_end
`ifdef VGA_TIMING_FRAME_CNT_EN
  , output logic [FRAME_W-1:0] frame_cnt
`endif
);

  localparam vga_timing_t H_CFG = '{active: H_ACTIVE, fp: H_FP, sync: H_SYNC, bp: H_BP};
  localparam vga_timing_t V_CFG = '{active: V_ACTIVE, fp: V_FP, sync: V_SYNC, bp: V_BP};
  localparam int unsigned H_TOTAL   = total(H_CFG);
  localparam int unsigned V_TOTAL   = total(V_CFG);
  localparam int unsigned H_SYNC_LO = H_ACTIVE + H_FP;
  localparam int unsigned H_SYNC_HI = H_SYNC_LO + H_SYNC;
  localparam int unsigned V_SYNC_LO = V_ACTIVE + V_FP;
  localparam int unsigned V_SYNC_HI = V_SYNC_LO + V_SYNC;

  if (CLK_DIV < 1 || H_ACTIVE == 0 || H_FP == 0 || H_SYNC == 0 || H_BP == 0 ||
      V_ACTIVE == 0 || V_FP == 0 || V_SYNC == 0 || V_BP == 0) begin : g_bad_cfg
    $error("vga_timing_gen: CLK_DIV must be >= 1 and every timing length non-zero");
  end

  logic [XW-1:0] h_cnt;
  logic [YW-1:0] v_cnt;
  logic          h_last;
  logic          v_last;
  logic          h_act;
  logic          v_act;
  logic          h_in_sync;
  logic          v_in_sync;

  vga_pixel_tick #(
    .CLK_DIV (CLK_DIV)
  ) u_tick (
    .clk    (clk),
    .reset  (reset),
    .en     (en),
    .p_tick (p_tick)
  );

  assign h_last = (h_cnt == XW'(H_TOTAL - 1));
  assign v_last = (v_cnt == YW'(V_TOTAL - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (p_tick) begin
      if (h_last) begin
        h_cnt <= '0;
        v_cnt <= v_last ? '0 : v_cnt + 1'b1;
      end else begin
        h_cnt <= h_cnt + 1'b1;
      end
    end
  end

  // Decode reads only the counter flops, so en never reaches these outputs combinationally.
  always_comb begin
    h_act     = (h_cnt < XW'(H_ACTIVE));
    v_act     = (v_cnt < YW'(V_ACTIVE));
    h_in_sync = (h_cnt >= XW'(H_SYNC_LO)) && (h_cnt < XW'(H_SYNC_HI));
    v_in_sync = (v_cnt >= YW'(V_SYNC_LO)) && (v_cnt < YW'(V_SYNC_HI));
    DE        = h_act && v_act;
    h_sync    = h_in_sync ? HS_POL : ~HS_POL;
    v_sync    = v_in_sync ? VS_POL : ~VS_POL;
    pixel_x   = DE ? h_cnt : '0;
    pixel_y   = DE ? v_cnt : '0;
  end

  assign line_end  = p_tick && h_last;
  assign frame_end = line_end && v_last;

`ifdef VGA_TIMING_FRAME_CNT_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      frame_cnt <= '0;
    end else if (frame_end) begin
      frame_cnt <= frame_cnt + 1'b1;
    end
  end
`endif

endmodule
